// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared widths, arbitration mode constants and defaults for the stream mux
package stream_mux_pkg;

   localparam int  DEFAULT_N  = 4;
   localparam int  DEFAULT_W  = 8;
   localparam logic MODE_RR    = 1'b1;
   localparam logic MODE_FIXED = 1'b0;

   // Select width is never narrower than one bit, even for a single channel.
   function automatic int sel_width(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority arbiter
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter  int N  = DEFAULT_N,
   localparam int SW = sel_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   input  logic          mode,
   output logic [N-1:0]  gnt,
   output logic [SW-1:0] gnt_idx,
   output logic          gnt_valid
);

   int start;
   int idx;

   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      idx       = 0;
      start     = ((mode == MODE_RR) && (int'(ptr) < N)) ? int'(ptr) : 0;
      // Scan from the start channel upward, wrapping past N-1; first requester wins.
      for (int k = 0; k < N; k++) begin
         idx = start + k;
         if (idx >= N) idx = idx - N;
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SW'(idx);
            gnt[idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N:1 registered valid/ready stream mux; STREAM_MUX_FORCE_SEL_EN adds forced select
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter  int N  = DEFAULT_N,
   parameter  int W  = DEFAULT_W,
   parameter  int RR = 1,
   localparam int SW = sel_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]  in_valid,
   output logic [N-1:0]  in_ready,
   output logic [W-1:0]  out_data,
   output logic [SW-1:0] out_sel,
   output logic          out_valid,
`ifdef STREAM_MUX_FORCE_SEL_EN
   input  logic          force_en,
   input  logic [SW-1:0] force_sel,
`endif
   input  logic          out_ready
);

   localparam logic ARB_MODE = (RR != 0) ? MODE_RR : MODE_FIXED;

   logic [SW-1:0] ptr_q, ptr_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic [SW-1:0] out_sel_q, out_sel_d;
   logic          out_valid_q, out_valid_d;

   logic [N-1:0]  arb_gnt;
   logic [SW-1:0] arb_idx;
   logic          arb_valid;

   logic [N-1:0]  gnt;
   logic [SW-1:0] gnt_idx;
   logic          gnt_valid;
   logic          forced;
   logic          load;
   logic [W-1:0]  sel_data;

   rr_arbiter #(.N(N)) u_arb (
      .req       (in_valid),
      .ptr       (ptr_q),
      .mode      (ARB_MODE),
      .gnt       (arb_gnt),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

`ifdef STREAM_MUX_FORCE_SEL_EN
   always_comb begin
      forced    = force_en;
      gnt       = arb_gnt;
      gnt_idx   = arb_idx;
      gnt_valid = arb_valid;
      if (force_en) begin
         gnt       = '0;
         gnt_idx   = force_sel;
         gnt_valid = 1'b0;
         if ((int'(force_sel) < N) && in_valid[force_sel]) begin
            gnt_valid      = 1'b1;
            gnt[force_sel] = 1'b1;
         end
      end
   end
`else
   always_comb begin
      forced    = 1'b0;
      gnt       = arb_gnt;
      gnt_idx   = arb_idx;
      gnt_valid = arb_valid;
   end
`endif

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) sel_data = in_data[i*W +: W];
      end
   end

   always_comb begin
      load        = ~out_valid_q | out_ready;
      in_ready    = (rst_n && load) ? gnt : '0;
      ptr_d       = ptr_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      if (load) begin
         if (gnt_valid) begin
            out_data_d  = sel_data;
            out_sel_d   = gnt_idx;
            out_valid_d = 1'b1;
            // Forced transfers leave the fairness pointer where round-robin left it.
            if ((RR != 0) && !forced) begin
               ptr_d = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr (round-robin and fixed-priority instances)
module tb_stream_mux_rr;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   logic           clk;
   logic           rst_n;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic           out_ready;
   logic [N-1:0]   rdy_a, rdy_b;
   logic [W-1:0]   data_a, data_b;
   logic [SW-1:0]  sel_a, sel_b;
   logic           val_a, val_b;
`ifdef STREAM_MUX_FORCE_SEL_EN
   logic           force_en;
   logic [SW-1:0]  force_sel;
`endif

   int n_cmp = 0;
   int n_err = 0;

   int          m_ptr;
   bit          m_val [2];
   logic [W-1:0] m_data [2];
   int          m_sel [2];

   stream_mux_rr #(.N(N), .W(W), .RR(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
      .out_data(data_a), .out_sel(sel_a), .out_valid(val_a),
`ifdef STREAM_MUX_FORCE_SEL_EN
      .force_en(force_en), .force_sel(force_sel),
`endif
      .out_ready(out_ready)
   );

   stream_mux_rr #(.N(N), .W(W), .RR(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
      .out_data(data_b), .out_sel(sel_b), .out_valid(val_b),
`ifdef STREAM_MUX_FORCE_SEL_EN
      .force_en(force_en), .force_sel(force_sel),
`endif
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic bit is_forced();
`ifdef STREAM_MUX_FORCE_SEL_EN
      return force_en;
`else
      return 1'b0;
`endif
   endfunction

   // Winner for model m (0 = round-robin, 1 = fixed), or -1 when nobody can be granted.
   function automatic int winner(input int m);
      int start;
`ifdef STREAM_MUX_FORCE_SEL_EN
      if (force_en) return (int'(force_sel) < N && in_valid[force_sel]) ? int'(force_sel) : -1;
`endif
      start = (m == 0) ? m_ptr : 0;
      for (int k = 0; k < N; k++) begin
         if (in_valid[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready(input int m);
      logic [N-1:0] r;
      int w;
      r = '0;
      if (rst_n && (!m_val[m] || out_ready)) begin
         w = winner(m);
         if (w >= 0) r[w] = 1'b1;
      end
      return r;
   endfunction

   task automatic model_clock();
      int w;
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            m_val[m] = 1'b0;
            m_data[m] = '0;
            m_sel[m] = 0;
            if (m == 0) m_ptr = 0;
         end else if (!m_val[m] || out_ready) begin
            w = winner(m);
            if (w >= 0) begin
               m_data[m] = in_data[w*W +: W];
               m_sel[m] = w;
               m_val[m] = 1'b1;
               if (m == 0 && !is_forced()) m_ptr = (w + 1) % N;
            end else begin
               m_val[m] = 1'b0;
            end
         end
      end
   endtask

   task automatic tick();
      model_clock();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = '1;
      out_ready = 1'b1;
      in_data = 32'h44332211;
      tick();
      tick();
      #1;
      n_cmp++; if (val_a !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", val_a); end
      n_cmp++; if (data_a !== 8'h00) begin n_err++; $display("FAIL reset_data: got %0h expected 0", data_a); end
      n_cmp++; if (sel_a !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d expected 0", sel_a); end
      n_cmp++; if (rdy_a !== 4'b0000) begin n_err++; $display("FAIL reset_ready_rr: got %b expected 0000", rdy_a); end
      n_cmp++; if (rdy_b !== 4'b0000 || val_b !== 1'b0) begin n_err++; $display("FAIL reset_fixed: got rdy %b val %0b expected 0000 0", rdy_b, val_b); end
   endtask

   task automatic test_rr_fairness();
      int seq [5] = '{0, 1, 2, 3, 0};
      logic [7:0] dd [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      logic [N-1:0] oh;
      rst_n = 1'b1;
      in_valid = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         oh = '0;
         oh[seq[i]] = 1'b1;
         n_cmp++; if (rdy_a !== oh) begin n_err++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, rdy_a, oh); end
         tick();
         n_cmp++; if (sel_a !== 2'(seq[i]) || data_a !== dd[i] || val_a !== 1'b1) begin
            n_err++; $display("FAIL rr_out[%0d]: got sel %0d data %0h val %0b expected %0d %0h 1", i, sel_a, data_a, val_a, seq[i], dd[i]);
         end
         n_cmp++; if (sel_b !== 2'd0 || data_b !== 8'h11) begin n_err++; $display("FAIL fixed_all_valid[%0d]: got sel %0d data %0h expected 0 11", i, sel_b, data_b); end
      end
   endtask

   task automatic test_fixed_priority();
      in_valid = 4'b1010;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (rdy_b !== 4'b0010) begin n_err++; $display("FAIL fixed_ready[%0d]: got %b expected 0010", i, rdy_b); end
         tick();
         n_cmp++; if (sel_b !== 2'd1 || data_b !== 8'h22 || val_b !== 1'b1) begin
            n_err++; $display("FAIL fixed_out[%0d]: got sel %0d data %0h val %0b expected 1 22 1", i, sel_b, data_b, val_b);
         end
         n_cmp++; if (sel_a !== 2'(m_sel[0])) begin n_err++; $display("FAIL rr_1010[%0d]: got %0d expected %0d", i, sel_a, m_sel[0]); end
      end
   endtask

   task automatic test_backpressure();
      logic [N-1:0] er;
      in_valid = 4'b0010;
      out_ready = 1'b1;
      tick();
      n_cmp++; if (data_a !== 8'h22 || val_a !== 1'b1) begin n_err++; $display("FAIL bp_load: got data %0h val %0b expected 22 1", data_a, val_a); end
      out_ready = 1'b0;
      in_valid = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (rdy_a !== 4'b0000 || rdy_b !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b/%b expected 0000", i, rdy_a, rdy_b); end
         tick();
         n_cmp++; if (data_a !== 8'h22 || sel_a !== 2'd1 || val_a !== 1'b1) begin
            n_err++; $display("FAIL bp_hold[%0d]: got data %0h sel %0d val %0b expected 22 1 1", i, data_a, sel_a, val_a);
         end
      end
      out_ready = 1'b1;
      #1;
      er = exp_ready(0);
      n_cmp++; if (rdy_a !== er || er == 4'b0000) begin n_err++; $display("FAIL bp_release_ready: got %b expected %b", rdy_a, er); end
      tick();
      n_cmp++; if (data_a !== m_data[0] || sel_a !== 2'(m_sel[0]) || val_a !== 1'b1) begin
         n_err++; $display("FAIL bp_release_out: got data %0h sel %0d expected %0h %0d", data_a, sel_a, m_data[0], m_sel[0]);
      end
   endtask

   task automatic test_wrap_hold();
      out_ready = 1'b1;
      in_valid = 4'b0100;
      tick();
      in_valid = 4'b0010;
      tick();
      n_cmp++; if (sel_a !== 2'd1 || data_a !== 8'h22) begin n_err++; $display("FAIL wrap_grant: got sel %0d data %0h expected 1 22", sel_a, data_a); end
      in_valid = 4'b0000;
      tick();
      tick();
      n_cmp++; if (val_a !== 1'b0 || sel_a !== 2'd1 || data_a !== 8'h22) begin
         n_err++; $display("FAIL idle_hold: got val %0b sel %0d data %0h expected 0 1 22", val_a, sel_a, data_a);
      end
      in_valid = 4'b1111;
      tick();
      n_cmp++; if (sel_a !== 2'd2) begin n_err++; $display("FAIL ptr_held: got sel %0d expected 2", sel_a); end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      in_valid = 4'b1111;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (rdy_a !== 4'b0000) begin n_err++; $display("FAIL midrst_ready: got %b expected 0000", rdy_a); end
      tick();
      n_cmp++; if (val_a !== 1'b0 || data_a !== 8'h00 || sel_a !== 2'd0) begin
         n_err++; $display("FAIL midrst_out: got val %0b data %0h sel %0d expected 0 0 0", val_a, data_a, sel_a);
      end
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      n_cmp++; if (sel_a !== 2'd0 || data_a !== 8'h11) begin n_err++; $display("FAIL midrst_ptr: got sel %0d data %0h expected 0 11", sel_a, data_a); end
   endtask

`ifdef STREAM_MUX_FORCE_SEL_EN
   task automatic test_force();
      force_en = 1'b1;
      force_sel = 2'd2;
      in_valid = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (sel_a !== 2'd2 || sel_b !== 2'd2 || data_a !== 8'h33) begin
            n_err++; $display("FAIL force_sel[%0d]: got %0d/%0d data %0h expected 2 33", i, sel_a, sel_b, data_a);
         end
      end
      force_en = 1'b0;
      tick();
      n_cmp++; if (sel_a !== 2'd1) begin n_err++; $display("FAIL force_ptr: got sel %0d expected 1", sel_a); end
   endtask
`endif

   task automatic test_random();
      logic [N-1:0] ea, eb;
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 40) != 0);
         in_valid = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data = $urandom;
`ifdef STREAM_MUX_FORCE_SEL_EN
         force_en = ($urandom_range(0, 5) == 0);
         force_sel = SW'($urandom);
`endif
         #1;
         ea = exp_ready(0);
         eb = exp_ready(1);
         n_cmp++; if (rdy_a !== ea || rdy_b !== eb) begin n_err++; $display("FAIL rand_ready[%0d]: got %b/%b expected %b/%b", i, rdy_a, rdy_b, ea, eb); end
         tick();
         n_cmp++; if (val_a !== m_val[0] || data_a !== m_data[0] || sel_a !== 2'(m_sel[0])) begin
            n_err++; $display("FAIL rand_rr[%0d]: got v%0b d%0h s%0d expected v%0b d%0h s%0d", i, val_a, data_a, sel_a, m_val[0], m_data[0], m_sel[0]);
         end
         n_cmp++; if (val_b !== m_val[1] || data_b !== m_data[1] || sel_b !== 2'(m_sel[1])) begin
            n_err++; $display("FAIL rand_fixed[%0d]: got v%0b d%0h s%0d expected v%0b d%0h s%0d", i, val_b, data_b, sel_b, m_val[1], m_data[1], m_sel[1]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = '0;
      in_data = '0;
      out_ready = 1'b0;
      m_ptr = 0;
      for (int m = 0; m < 2; m++) begin
         m_val[m] = 1'b0;
         m_data[m] = '0;
         m_sel[m] = 0;
      end
`ifdef STREAM_MUX_FORCE_SEL_EN
      force_en = 1'b0;
      force_sel = '0;
`endif
      test_reset();
      test_rr_fairness();
      test_fixed_priority();
      test_backpressure();
      test_wrap_hold();
      test_mid_reset();
`ifdef STREAM_MUX_FORCE_SEL_EN
      test_force();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
